onewire_master: RTL

//  Synthesizable 1-Wire bus master for the gh18b20 temperature sensor path, sitting

---
 rtl/onewire_master_if.sv | 24 ++
 rtl/onewire_master.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/onewire_master_if.sv
// Command/response handshake and dq pad signals for the 1-Wire master.
// The "slave" modport is the onewire_master side; "master" is the sequencer/pad side.
interface onewire_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       busy;
    logic       dq_oe;
    logic       dq_in;

    modport master (
        output cmd_valid, cmd_op, cmd_data, dq_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, busy, dq_oe
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, dq_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, busy, dq_oe
    );
endinterface

// File: rtl/onewire_master.sv
// Standard-speed 1-Wire bus master: bus reset with presence detect, byte write and
// byte read (LSB first), all timing derived from a free-running microsecond tick.
module onewire_master #(
    parameter int CLK_DIV     = 50,
    parameter int T_RST       = 480,
    parameter int T_PD_SAMPLE = 70,
    parameter int T_SLOT      = 60,
    parameter int T_REC       = 2,
    parameter int T_LOW1      = 6,
    parameter int T_RD_SAMPLE = 15
) (
    input logic             clk,
    input logic             rst_start,
    onewire_master_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int UW = $clog2(T_RST + T_SLOT + 1) + 1;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_REL, SLOT_REC, DONE
    } state_e;

    state_e         state_q;
    logic [PW-1:0]  ps_q;
    logic [UW-1:0]  us_q;
    logic [2:0]     bit_q;
    logic [1:0]     op_q;
    logic [7:0]     wr_q;
    logic [7:0]     sh_q;
    logic           pd_q;
    logic           cmd_ready_q;
    logic           rsp_valid_q;
    logic [7:0]     rsp_data_q;
    logic           rsp_pres_q;
    logic           dq_oe_q;
    logic           dq_meta_q;
    logic           dq_sync_q;
    logic           tick;
    logic [UW-1:0]  low_end;

    assign tick    = (ps_q == PW'(CLK_DIV - 1));
    // Write-0 holds the line for the whole slot; write-1 and read only pulse it.
    assign low_end = (op_q == OP_RD || wr_q[bit_q]) ? UW'(T_LOW1 - 1) : UW'(T_SLOT - 1);

    always_ff @(posedge clk or posedge rst_start) begin
        if (rst_start) ps_q <= '0;
        else           ps_q <= tick ? '0 : ps_q + PW'(1);
    end

    // Idle level of a pulled-up bus is high.
    always_ff @(posedge clk or posedge rst_start) begin
        if (rst_start) begin
            dq_meta_q <= 1'b1;
            dq_sync_q <= 1'b1;
        end else begin
            dq_meta_q <= bus.dq_in;
            dq_sync_q <= dq_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst_start) begin
        if (rst_start) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_pres_q  <= 1'b0;
            dq_oe_q     <= 1'b0;
            op_q        <= 2'b00;
            wr_q        <= 8'h00;
            sh_q        <= 8'h00;
            pd_q        <= 1'b0;
            us_q        <= '0;
            bit_q       <= 3'd0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q        <= bus.cmd_op;
                    wr_q        <= bus.cmd_data;
                    sh_q        <= 8'h00;
                    us_q        <= '0;
                    bit_q       <= 3'd0;
                    cmd_ready_q <= 1'b0;
                    case (bus.cmd_op)
                        OP_RST: begin
                            dq_oe_q <= 1'b1;
                            state_q <= RST_LOW;
                        end
                        OP_WR, OP_RD: begin
                            dq_oe_q <= 1'b1;
                            state_q <= SLOT_LOW;
                        end
                        default: begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    endcase
                end
                RST_LOW: if (tick) begin
                    if (us_q == UW'(T_RST - 1)) begin
                        us_q    <= '0;
                        dq_oe_q <= 1'b0;
                        state_q <= RST_WAIT;
                    end else begin
                        us_q <= us_q + UW'(1);
                    end
                end
                RST_WAIT: if (tick) begin
                    us_q <= us_q + UW'(1);
                    if (us_q == UW'(T_PD_SAMPLE - 1)) pd_q <= ~dq_sync_q;
                    if (us_q == UW'(T_RST - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_pres_q  <= pd_q;
                        state_q     <= DONE;
                    end
                end
                SLOT_LOW: if (tick) begin
                    us_q <= us_q + UW'(1);
                    if (us_q == low_end) begin
                        dq_oe_q <= 1'b0;
                        state_q <= SLOT_REL;
                    end
                end
                // us_q keeps counting from slot start so the sample point is slot-relative.
                SLOT_REL: begin
                    if (us_q >= UW'(T_SLOT)) begin
                        us_q    <= '0;
                        state_q <= SLOT_REC;
                    end else if (tick) begin
                        us_q <= us_q + UW'(1);
                        if (op_q == OP_RD && us_q == UW'(T_RD_SAMPLE - 1)) sh_q[bit_q] <= dq_sync_q;
                    end
                end
                SLOT_REC: if (tick) begin
                    if (us_q == UW'(T_REC - 1)) begin
                        us_q <= '0;
                        if (bit_q == 3'd7) begin
                            rsp_valid_q <= 1'b1;
                            if (op_q == OP_RD) rsp_data_q <= sh_q;
                            state_q <= DONE;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            dq_oe_q <= 1'b1;
                            state_q <= SLOT_LOW;
                        end
                    end else begin
                        us_q <= us_q + UW'(1);
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = ~cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_presence = rsp_pres_q;
    assign bus.dq_oe        = dq_oe_q;
endmodule
